// File: rtl/key_event_fifo_pkg.sv
// rtl/key_event_fifo_pkg.sv - shared key width, queue depth and issue FSM states
//
// Purpose: constants shared by the keypad, key_event_fifo and lcd_ctrl, plus
//          the state type of the downstream issue FSM.
// Ports:   none (package).
package key_event_fifo_pkg;

  localparam int KEY_W      = 7;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } issue_state_e;

endpackage

// File: rtl/key_event_fifo_mem.sv
// rtl/key_event_fifo_mem.sv - DEPTH x DATA_W register array for queued key codes
//
// Purpose: storage for key_event_fifo. Synchronous write, combinational read.
//          Storage is deliberately not reset; validity is tracked by the
//          pointers and count in the parent.
// Ports:   clk            clock
//          we/waddr/wdata write port
//          raddr/rdata    combinational read port
module key_fifo_mem
  import key_event_fifo_pkg::*;
#(
  parameter int DATA_W = KEY_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - keypad code queue issuing one send strobe per downstream done
//
// Purpose: queues 7-bit key codes from the keypad synchronizer and hands them
//          to lcd_ctrl one at a time: a one-cycle out_send per code, the next
//          code only after out_done.
// Ports:   clk       250 kHz domain clock
//          rst       asynchronous reset, active-low
//          flush     synchronous queue clear, active-high
//          in_valid  key-ready level (rising edge = one key), in_data key code
//          out_data  code presented downstream, held until next issue
//          out_send  one-cycle issue strobe
//          out_done  downstream transfer complete pulse
//          count     entries queued (0..DEPTH)
//          overflow  sticky: a key was dropped because the queue was full
module key_event_fifo
  import key_event_fifo_pkg::*;
#(
  parameter int DATA_W = KEY_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_send,
  input  logic              out_done,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic              in_valid_q, in_valid_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_send_q, out_send_d;
  issue_state_e      state_q, state_d;

  logic              push_req;
  logic              full;
  logic              push_ok;
  logic              pop;
  logic [DATA_W-1:0] rdata;

  // Full is taken from the count at the start of the cycle, so a push that
  // lands together with a pop while full is still dropped.
  assign push_req = in_valid & ~in_valid_q;
  assign full     = (count_q == CNT_FULL);
  assign push_ok  = push_req & ~full & ~flush;
  assign pop      = (state_q == ST_IDLE) && (count_q != '0) && !flush;

  key_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Pointers, count and overflow. Flush wins over everything, and a push
  // dropped by flush does not count as an overflow.
  always_comb begin
    in_valid_d = in_valid;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push_ok && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (!push_ok && pop) begin
        count_d = count_q - CNT_ONE;
      end
      if (push_req && full) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Issue FSM. A transfer already in SEND/WAIT runs to out_done even across a
  // flush; out_data is only reloaded on an issue.
  always_comb begin
    state_d    = state_q;
    out_send_d = 1'b0;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          out_data_d = rdata;
          out_send_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (out_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
      out_send_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      in_valid_q <= in_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
      out_send_q <= out_send_d;
      state_q    <= state_d;
    end
  end

  assign out_data = out_data_q;
  assign out_send = out_send_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// tb/tb_key_event_fifo.sv - directed self-checking bench for key_event_fifo
module tb_key_event_fifo;
  import key_event_fifo_pkg::*;

  localparam int DW = 7;
  localparam int AW = 3;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          flush    = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_done = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic [DW-1:0] out_data;
  logic          out_send;
  logic [AW:0]   count;
  logic          overflow;

  int checks  = 0;
  int errors  = 0;
  int n_sends = 0;
  int base;
  logic [DW-1:0] got[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  key_event_fifo #(.DATA_W(DW), .DEPTH(8), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_data (out_data),
    .out_send (out_send),
    .out_done (out_done),
    .count    (count),
    .overflow (overflow)
  );

  always @(negedge clk) begin
    if (rst && out_send) begin
      n_sends++;
      got.push_back(out_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [DW-1:0] code);
    in_valid = 1'b1;
    in_data  = code;
    tick(1);
    in_valid = 1'b0;
    tick(1);
  endtask

  task automatic done_pulse();
    out_done = 1'b1;
    tick(1);
    out_done = 1'b0;
  endtask

  initial begin
    // reset values
    tick(2);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_send", 32'(out_send), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    rst = 1'b1;
    tick(1);
    chk("idle_no_send", 32'(n_sends), 32'd0);

    // single key held high for 5 cycles
    in_data  = 7'h31;
    in_valid = 1'b1;
    tick(1);
    chk("t1_count_after_push", 32'(count), 32'd1);
    chk("t1_no_send_yet", 32'(out_send), 32'h0);
    tick(1);
    chk("t1_send", 32'(out_send), 32'h1);
    chk("t1_data", 32'(out_data), 32'h31);
    chk("t1_count_zero", 32'(count), 32'd0);
    tick(3);
    in_valid = 1'b0;
    chk("t1_one_send", 32'(n_sends), 32'd1);
    done_pulse();
    tick(3);
    chk("t1_no_extra_send", 32'(n_sends), 32'd1);

    // queue drain, one issue per done, one cycle after done
    got.delete();
    press(7'h30);
    press(7'h31);
    press(7'h32);
    press(7'h33);
    chk("t2_count3", 32'(count), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      out_done = 1'b1;
      tick(1);
      out_done = 1'b0;
      chk("t2_no_send_at_done", 32'(out_send), 32'h0);
      tick(1);
      chk("t2_send", 32'(out_send), 32'h1);
      chk("t2_data", 32'(out_data), 32'h30 + 32'(i));
      tick(8);
    end
    done_pulse();
    tick(3);
    chk("t2_count0", 32'(count), 32'd0);
    chk("t2_nsent", 32'(got.size()), 32'd4);

    // full queue and overflow
    got.delete();
    press(7'h3F);
    for (int i = 0; i < 8; i++) press(7'(8'h40 + i));
    chk("t3_count_full", 32'(count), 32'd8);
    chk("t3_no_overflow_yet", 32'(overflow), 32'h0);
    press(7'h48);
    chk("t3_count_still_full", 32'(count), 32'd8);
    chk("t3_overflow", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) begin
      done_pulse();
      tick(3);
    end
    done_pulse();
    tick(2);
    chk("t3_nsent", 32'(got.size()), 32'd9);
    if (got.size() == 9) begin
      chk("t3_first", 32'(got[0]), 32'h3F);
      for (int i = 0; i < 8; i++) chk("t3_order", 32'(got[i+1]), 32'h40 + 32'(i));
    end
    chk("t3_overflow_sticky", 32'(overflow), 32'h1);
    chk("t3_count_empty", 32'(count), 32'd0);

    // flush while a transfer is in WAIT with three queued
    got.delete();
    press(7'h50);
    press(7'h51);
    press(7'h52);
    press(7'h53);
    chk("t4_count3", 32'(count), 32'd3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("t4_count0", 32'(count), 32'd0);
    chk("t4_overflow_clr", 32'(overflow), 32'h0);
    chk("t4_data_held", 32'(out_data), 32'h50);
    done_pulse();
    tick(6);
    chk("t4_no_more_send", 32'(got.size()), 32'd1);

    // wrap with pushes landing on the same edge as IDLE pops
    got.delete();
    exp_q.delete();
    press(7'h5A); exp_q.push_back(7'h5A);
    press(7'h5B); exp_q.push_back(7'h5B);
    press(7'h5C); exp_q.push_back(7'h5C);
    for (int i = 0; i < 20; i++) begin
      out_done = 1'b1;
      tick(1);
      out_done = 1'b0;
      in_valid = 1'b1;
      in_data  = 7'(8'h60 + i);
      exp_q.push_back(7'(8'h60 + i));
      tick(1);
      in_valid = 1'b0;
      chk("t5_count", 32'(count), 32'd2);
      chk("t5_send", 32'(out_send), 32'h1);
      tick(2);
    end
    repeat (2) begin
      done_pulse();
      tick(3);
    end
    done_pulse();
    tick(2);
    chk("t5_nsent", 32'(got.size()), 32'd23);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk("t5_order", 32'(got[i]), 32'(exp_q[i]));
    end
    chk("t5_count0", 32'(count), 32'd0);
    chk("t5_no_overflow", 32'(overflow), 32'h0);

    // async reset while in SEND
    press(7'h11);
    chk("t6_in_send", 32'(out_send), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("t6_send_rst_send", 32'(out_send), 32'h0);
    chk("t6_send_rst_data", 32'(out_data), 32'h0);
    tick(1);
    rst = 1'b1;
    base = n_sends;
    done_pulse();
    tick(4);
    chk("t6_send_stale_done", 32'(n_sends), 32'(base));

    // async reset while in WAIT with one queued
    press(7'h22);
    press(7'h23);
    chk("t6_wait_count1", 32'(count), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_wait_rst_count", 32'(count), 32'd0);
    chk("t6_wait_rst_data", 32'(out_data), 32'h0);
    tick(1);
    rst = 1'b1;
    base = n_sends;
    done_pulse();
    tick(4);
    chk("t6_wait_stale_done", 32'(n_sends), 32'(base));
    chk("t6_wait_count_after", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
